// File: rtl/fpa_arbiter_pkg.sv
// Shared definitions for adder-side controllers: FSM state encoding,
// response status codes and an index-width helper.
package fpa_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_EXC = 2'b01;
    localparam logic [1:0] ERR_TMO = 2'b10;

    // Width of an index into n items (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fpa_arbiter_rr_pick.sv
// Combinational round-robin selector: first set bit of i_req at or after
// i_ptr, searching upward with wrap from N_REQ-1 to 0.
module fpa_arbiter_rr_pick
    import fpa_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW   = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic             o_valid,
    output logic [N_REQ-1:0] o_gnt,
    output logic [IW-1:0]    o_idx
);

    logic [IW:0] w_sum;

    // Scan offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        o_valid = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N_REQ))
                w_sum = w_sum - (IW+1)'(N_REQ);
            if (i_req[w_sum[IW-1:0]]) begin
                o_valid                 = 1'b1;
                o_idx                   = w_sum[IW-1:0];
                o_gnt                   = '0;
                o_gnt[w_sum[IW-1:0]]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpa_arbiter.sv
// Round-robin arbiter/sequencer sharing one floating-point adder among
// N_REQ requesters: grant, start, wait for done/exception/timeout, respond.
module fpa_arbiter
    import fpa_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input  logic               clk,
    input  logic               clr,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] a_in,
    input  logic [N_REQ*W-1:0] b_in,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   rsp_valid,
    output logic [W-1:0]       rsp_data,
    output logic [1:0]         rsp_err,
    output logic               fpa_start,
    output logic [W-1:0]       fpa_a,
    output logic [W-1:0]       fpa_b,
    output logic               fpa_clr,
    input  logic               fpa_done,
    input  logic               fpa_except,
    input  logic [W-1:0]       fpa_result,
    output logic               busy
);

    localparam int IW = idx_w(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    arb_state_t     r_state, w_next;
    logic [IW-1:0]  r_ptr, r_owner;
    logic [TW-1:0]  r_timer;
    logic           w_pick_valid;
    logic [N_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]  w_pick_idx;
    logic           w_exc, w_done, w_tmo;

    fpa_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx)
    );

    // Completion events are only meaningful in WAIT; exception beats done beats timeout.
    assign w_exc  = (r_state == ST_WAIT) && fpa_except;
    assign w_done = (r_state == ST_WAIT) && fpa_done && !fpa_except;
    assign w_tmo  = (r_state == ST_WAIT) && !fpa_done && !fpa_except &&
                    (r_timer == TW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (clr) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_pick_valid) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (w_exc || w_done || w_tmo) w_next = ST_RESP;
            ST_RESP:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Pulse outputs decoded from state and owner.
    always_comb begin
        gnt       = '0;
        rsp_valid = '0;
        fpa_start = 1'b0;
        fpa_clr   = 1'b0;
        busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_ISSUE: begin
                gnt[r_owner] = 1'b1;
                fpa_start    = 1'b1;
            end
            ST_WAIT:  fpa_clr = w_tmo;
            ST_RESP:  rsp_valid[r_owner] = 1'b1;
            default:  ;
        endcase
    end

    // Datapath: owner/operand capture, timeout timer, response and pointer update.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_ptr    <= '0;
            r_owner  <= '0;
            r_timer  <= '0;
            fpa_a    <= '0;
            fpa_b    <= '0;
            rsp_data <= '0;
            rsp_err  <= ERR_OK;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner <= w_pick_idx;
                        fpa_a   <= a_in[int'(w_pick_idx)*W +: W];
                        fpa_b   <= b_in[int'(w_pick_idx)*W +: W];
                    end
                end
                ST_ISSUE: r_timer <= '0;
                ST_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_exc) begin
                        rsp_err  <= ERR_EXC;
                        rsp_data <= '0;
                    end else if (w_done) begin
                        rsp_err  <= ERR_OK;
                        rsp_data <= fpa_result;
                    end else if (w_tmo) begin
                        rsp_err  <= ERR_TMO;
                    end
                end
                ST_RESP: r_ptr <= (r_owner == IW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpa_arbiter.sv
// Self-checking bench for fpa_arbiter: directed scenarios plus randomized
// operations compared against a transaction-level arbitration model.
module tb_fpa_arbiter;
    import fpa_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           clr;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   gnt, rsp_valid;
    logic [W-1:0]   rsp_data, fpa_a, fpa_b, fpa_result;
    logic [1:0]     rsp_err;
    logic           fpa_start, fpa_clr, fpa_done, fpa_except, busy;

    int checks = 0;
    int errors = 0;
    int ptr_m  = 0;          // model round-robin pointer
    logic [W-1:0] data_m = '0; // model of held rsp_data

    fpa_arbiter #(.N_REQ(N), .W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .clr(clr), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .fpa_start(fpa_start), .fpa_a(fpa_a), .fpa_b(fpa_b), .fpa_clr(fpa_clr),
        .fpa_done(fpa_done), .fpa_except(fpa_except), .fpa_result(fpa_result),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: first requester at or after p, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction, entered in an IDLE cycle.
    // kind: 0 done, 1 except, 2 done+except, 3 adder silent.
    task automatic op(input logic [N-1:0] r, input int kind, input int lat, input logic hold,
                      input logic fixed, input logic [W-1:0] fa, input logic [W-1:0] fb,
                      input logic [W-1:0] res, input logic [N-1:0] wdr);
        int w;
        logic [W-1:0] av [N];
        logic [W-1:0] bv [N];
        logic [1:0] err_e;
        w = pick(r, ptr_m);
        for (int i = 0; i < N; i++) begin
            av[i] = W'($urandom);
            bv[i] = W'($urandom);
        end
        if (fixed) begin
            av[w] = fa;
            bv[w] = fb;
        end
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = av[i];
            b_in[i*W +: W] = bv[i];
        end
        req = r;
        tick();
        chk("gnt", 32'(gnt), 32'(1 << w));
        chk("fpa_start", 32'(fpa_start), 32'd1);
        chk("fpa_a", 32'(fpa_a), 32'(av[w]));
        chk("fpa_b", 32'(fpa_b), 32'(bv[w]));
        chk("issue_busy", 32'(busy), 32'd1);
        if (!hold) req = '0;
        for (int k = 1; k <= TO; k++) begin
            tick();
            fpa_done = 1'b0;
            fpa_except = 1'b0;
            if (wdr != '0 && k == 1) req = wdr;
            if (wdr != '0 && k == 2) req = '0;
            if (kind != 3 && k == lat) begin
                fpa_done   = (kind == 0 || kind == 2);
                fpa_except = (kind == 1 || kind == 2);
                fpa_result = res;
            end
            #1;
            chk("wait_gnt", 32'(gnt | rsp_valid), 32'd0);
            chk("wait_start", 32'(fpa_start), 32'd0);
            chk("fpa_clr", 32'(fpa_clr), 32'(kind == 3 && k == TO));
            if ((kind != 3 && k == lat) || k == TO) break;
        end
        tick();
        fpa_done = 1'b0;
        fpa_except = 1'b0;
        #1;
        err_e = (kind == 0) ? ERR_OK : (kind == 3) ? ERR_TMO : ERR_EXC;
        if (kind == 0) data_m = res;
        if (kind == 1 || kind == 2) data_m = '0;
        chk("rsp_valid", 32'(rsp_valid), 32'(1 << w));
        chk("rsp_err", 32'(rsp_err), 32'(err_e));
        if (kind != 1) chk("rsp_data", 32'(rsp_data), 32'(data_m));
        chk("resp_clr", 32'(fpa_clr), 32'd0);
        ptr_m = (w + 1) % N;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rsp", 32'(rsp_valid | gnt), 32'd0);
        chk("hold_data", 32'(rsp_data), 32'(data_m));
        chk("hold_a", 32'(fpa_a), 32'(av[w]));
    endtask

    initial begin
        clr = 1'b1; req = '0; a_in = '0; b_in = '0;
        fpa_done = 1'b0; fpa_except = 1'b0; fpa_result = '0;
        tick(); tick();
        chk("rst_outs", 32'({gnt, rsp_valid, fpa_start, fpa_clr, busy}), 32'd0);
        chk("rst_data", 32'({rsp_data, rsp_err, fpa_a, fpa_b}), 32'd0);
        clr = 1'b0;
        tick();

        // Single request, done 3 cycles after start.
        op(4'b0001, 0, 3, 1'b0, 1'b1, 8'h3C, 8'h14, 8'h50, '0);

        // Contention with all requests held: 1,2,3,0,1 given ptr=1 now.
        for (int i = 0; i < 5; i++)
            op(4'b1111, 0, 1 + (i % 3), 1'b1, 1'b0, '0, '0, W'($urandom), '0);

        // Exception, done+except, timeout, done exactly at last WAIT cycle.
        op(4'b0010, 1, 2,  1'b0, 1'b0, '0, '0, 8'hAA, '0);
        op(4'b0110, 0, 2,  1'b0, 1'b0, '0, '0, 8'h77, '0);
        op(4'b0110, 2, 3,  1'b0, 1'b0, '0, '0, 8'h55, '0);
        op(4'b1000, 3, 0,  1'b0, 1'b0, '0, '0, 8'h00, '0);
        op(4'b0001, 0, TO, 1'b0, 1'b0, '0, '0, 8'hC3, '0);

        // Leave ptr=3, then reset mid-WAIT of an operation owned by 3.
        op(4'b0100, 0, 1, 1'b0, 1'b0, '0, '0, 8'h11, '0);
        req = 4'b1000;
        tick(); req = '0;
        tick(); tick();
        clr = 1'b1;
        tick(); clr = 1'b0;
        chk("mid_rst_outs", 32'({gnt, rsp_valid, fpa_start, fpa_clr, busy}), 32'd0);
        chk("mid_rst_data", 32'({rsp_data, rsp_err, fpa_a, fpa_b}), 32'd0);
        ptr_m = 0; data_m = '0;
        fpa_done = 1'b1; fpa_result = 8'hEE;
        tick(); fpa_done = 1'b0;
        chk("late_done", 32'({rsp_valid, busy}), 32'd0);
        tick();
        chk("late_done2", 32'({rsp_valid, busy, rsp_data}), 32'd0);
        // With ptr reset to 0, requester 2 wins over 3.
        op(4'b1100, 0, 2, 1'b0, 1'b0, '0, '0, 8'h21, '0);

        // Withdrawn request while busy: no grant, pointer untouched.
        op(4'b0001, 0, 3, 1'b0, 1'b0, '0, '0, 8'h42, 4'b0010);
        tick();
        chk("wd_nognt", 32'({gnt, busy}), 32'd0);
        tick();
        chk("wd_nognt2", 32'({gnt, busy}), 32'd0);
        op(4'b1111, 0, 1, 1'b0, 1'b0, '0, '0, 8'h99, '0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            if (kind > 3) kind = 0;
            op(N'($urandom_range(1, (1 << N) - 1)), kind, int'($urandom_range(1, TO)),
               1'b0, 1'b0, '0, '0, W'($urandom), '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
